// File: rtl/attn_job_sched.sv
// attn_job_sched: round-robin scheduler that shares one attention engine among NREQ requesters.
// Optional watchdog: define ATTN_JOB_SCHED_WATCHDOG_EN to abort RUN after TIMEOUT cycles.
module attn_job_sched #(
    parameter int unsigned NREQ    = 2,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*512-1:0]  req_key,
    input  logic [NREQ*512-1:0]  req_query,
    input  logic [NREQ*512-1:0]  req_value,
    output logic                 eng_en,
    output logic                 eng_rst_n,
    output logic [511:0]         eng_key,
    output logic [511:0]         eng_query,
    output logic [511:0]         eng_value,
    input  logic [511:0]         eng_final_res,
    input  logic                 eng_all_done,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [1:0]           rsp_id,
    output logic [511:0]         rsp_data,
    output logic                 rsp_err,
    output logic                 busy,
    output logic [7:0]           job_count
);
    localparam int unsigned DW = 512;
    localparam int unsigned IW = 2;
    localparam int unsigned CW = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [IW-1:0] rr_ptr;
    logic          grant_vld;
    logic [IW-1:0] grant_idx;
    logic [2:0]    cand;
    logic [3:0]    valid4;
    logic [DW-1:0] sel_key;
    logic [DW-1:0] sel_query;
    logic [DW-1:0] sel_value;
    logic          wd_hit;

    // Elaboration-time guard on the legal parameter ranges.
    if (NREQ < 1 || NREQ > 4) begin : g_bad_nreq
        $error("attn_job_sched: NREQ must be in 1..4");
    end
    if (TIMEOUT < 16 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("attn_job_sched: TIMEOUT must be in 16..65535");
    end

    assign valid4 = 4'(req_valid);

    // Round-robin: first valid index at or above rr_ptr, wrapping modulo NREQ.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_ptr} + 3'(k);
            if (cand >= 3'(NREQ)) begin
                cand = cand - 3'(NREQ);
            end
            if (!grant_vld && valid4[cand[1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[1:0];
            end
        end
    end

    always_comb begin
        sel_key   = '0;
        sel_query = '0;
        sel_value = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_idx == IW'(i)) begin
                sel_key   = req_key[i*DW +: DW];
                sel_query = req_query[i*DW +: DW];
                sel_value = req_value[i*DW +: DW];
            end
        end
    end

`ifdef ATTN_JOB_SCHED_WATCHDOG_EN
    logic [CW-1:0] run_cnt;

    // Counts RUN cycles; held at zero outside RUN so every accept starts fresh.
    always_ff @(posedge clk) begin
        if (rst || state != ST_RUN) begin
            run_cnt <= '0;
        end else begin
            run_cnt <= run_cnt + CW'(1);
        end
    end

    assign wd_hit = (run_cnt == CW'(TIMEOUT - 1));
`else
    assign wd_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (grant_vld) state_nx = ST_RUN;
            ST_RUN:  if (eng_all_done || wd_hit) state_nx = ST_RESP;
            ST_RESP: if (rsp_ready) state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Engine is held in reset outside RUN so it clears between jobs.
    always_comb begin
        eng_en    = 1'b0;
        eng_rst_n = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        req_ready = '0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                for (int unsigned i = 0; i < NREQ; i++) begin
                    req_ready[i] = grant_vld && (grant_idx == IW'(i));
                end
            end
            ST_RUN: begin
                eng_en    = 1'b1;
                eng_rst_n = 1'b1;
            end
            ST_RESP: rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Completion beats the watchdog when both land in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            job_count <= '0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            eng_key   <= '0;
            eng_query <= '0;
            eng_value <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant_vld) begin
                        eng_key   <= sel_key;
                        eng_query <= sel_query;
                        eng_value <= sel_value;
                        rsp_id    <= grant_idx;
                    end
                end
                ST_RUN: begin
                    if (eng_all_done) begin
                        rsp_data <= eng_final_res;
                        rsp_err  <= 1'b0;
                    end else if (wd_hit) begin
                        rsp_data <= '0;
                        rsp_err  <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rr_ptr    <= (rsp_id == IW'(NREQ - 1)) ? '0 : rsp_id + IW'(1);
                        job_count <= job_count + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_attn_job_sched.sv
// tb_attn_job_sched: directed, table-driven bench for attn_job_sched with a mock fixed-latency engine.
module tb_attn_job_sched;
    localparam int NREQ = 2;
    localparam int TO   = 16;
    localparam int DW   = 512;
`ifdef ATTN_JOB_SCHED_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    typedef struct {
        logic [1:0] vmask;
        int         lat;
        logic [7:0] res;
        logic [1:0] id;
        logic [7:0] jc;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*DW-1:0] req_key, req_query, req_value;
    logic              eng_en, eng_rst_n;
    logic [DW-1:0]     eng_key, eng_query, eng_value, eng_final_res;
    logic              eng_all_done;
    logic              rsp_valid, rsp_ready;
    logic [1:0]        rsp_id;
    logic [DW-1:0]     rsp_data;
    logic              rsp_err, busy;
    logic [7:0]        job_count;

    int            n_cmp = 0;
    int            n_err = 0;
    int            eng_lat = 0;
    int            eng_cycles = 0;
    logic [DW-1:0] eng_res = '0;
    vec_t          tbl [7];

    always #5 clk = ~clk;

    attn_job_sched #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_key(req_key), .req_query(req_query), .req_value(req_value),
        .eng_en(eng_en), .eng_rst_n(eng_rst_n),
        .eng_key(eng_key), .eng_query(eng_query), .eng_value(eng_value),
        .eng_final_res(eng_final_res), .eng_all_done(eng_all_done),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy), .job_count(job_count)
    );

    // Mock engine: done on its eng_lat-th enabled cycle; eng_lat=0 never finishes.
    always @(posedge clk) begin
        if (!eng_rst_n) eng_cycles <= 0;
        else if (eng_en) eng_cycles <= eng_cycles + 1;
    end
    assign eng_all_done  = eng_en && (eng_cycles == eng_lat - 1);
    assign eng_final_res = eng_res;

    function automatic logic [DW-1:0] pat(input logic [7:0] base, input logic [1:0] id);
        logic [7:0] b;
        b = base + 8'(id);
        return {64{b}};
    endfunction

    function automatic logic [1:0] onehot(input logic [1:0] id);
        return 2'(1) << id;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // One full job from IDLE with rsp_ready high; entered and left at #1 after an edge.
    task automatic run_job(input logic [1:0] vmask, input int lat, input logic [7:0] resb,
                           input logic [1:0] exp_id, input logic [7:0] exp_jc);
        bit            exp_err;
        int            exp_cnt;
        logic [DW-1:0] exp_data;
        int            cnt;
        int            n;
        int            bad;
        exp_err  = WD && (lat == 0 || lat > TO);
        exp_cnt  = exp_err ? TO : lat;
        exp_data = exp_err ? '0 : {64{resb}};
        eng_lat   = lat;
        eng_res   = {64{resb}};
        rsp_ready = 1'b1;
        req_valid = vmask;
        #1;
        chk("grant", DW'(req_ready), DW'(onehot(exp_id)));
        @(posedge clk);
        #1;
        chk("busy_run", DW'(busy), DW'(1'b1));
        chk("eng_key", eng_key, pat(8'hA0, exp_id));
        chk("eng_query", eng_query, pat(8'hB0, exp_id));
        chk("eng_value", eng_value, pat(8'hC0, exp_id));
        cnt = 0;
        n   = 0;
        bad = 0;
        while (!rsp_valid && n < 300) begin
            if (eng_en) cnt++;
            if (req_ready != '0) bad++;
            @(posedge clk);
            #1;
            n++;
        end
        chk("rsp_seen", DW'(rsp_valid), DW'(1'b1));
        chk("en_cycles", DW'(cnt), DW'(exp_cnt));
        chk("no_grant_run", DW'(bad), DW'(0));
        chk("rsp_id", DW'(rsp_id), DW'(exp_id));
        chk("rsp_data", rsp_data, exp_data);
        chk("rsp_err", DW'(rsp_err), DW'(exp_err));
        chk("en_resp", DW'(eng_en), DW'(1'b0));
        chk("rstn_resp", DW'(eng_rst_n), DW'(1'b0));
        chk("no_grant_resp", DW'(req_ready), DW'(0));
        @(posedge clk);
        #1;
        req_valid = '0;
        chk("idle_after", DW'(busy), DW'(1'b0));
        chk("rsp_drop", DW'(rsp_valid), DW'(1'b0));
        chk("job_count", DW'(job_count), DW'(exp_jc));
    endtask

    initial begin
        int n;
        tbl[0] = '{2'b01, 20, 8'h5A, 2'd0, 8'd1};
        tbl[1] = '{2'b01,  3, 8'h11, 2'd0, 8'd2};
        tbl[2] = '{2'b10,  5, 8'h22, 2'd1, 8'd3};
        tbl[3] = '{2'b11,  2, 8'h33, 2'd0, 8'd4};
        tbl[4] = '{2'b11,  4, 8'h44, 2'd1, 8'd5};
        tbl[5] = '{2'b11,  1, 8'h55, 2'd0, 8'd6};
        tbl[6] = '{2'b11,  7, 8'h66, 2'd1, 8'd7};

        req_key   = {pat(8'hA0, 2'd1), pat(8'hA0, 2'd0)};
        req_query = {pat(8'hB0, 2'd1), pat(8'hB0, 2'd0)};
        req_value = {pat(8'hC0, 2'd1), pat(8'hC0, 2'd0)};
        rsp_ready = 1'b0;
        do_reset();

        chk("rst_busy", DW'(busy), DW'(1'b0));
        chk("rst_rsp_valid", DW'(rsp_valid), DW'(1'b0));
        chk("rst_rsp_err", DW'(rsp_err), DW'(1'b0));
        chk("rst_rsp_id", DW'(rsp_id), DW'(0));
        chk("rst_rsp_data", rsp_data, '0);
        chk("rst_eng_key", eng_key, '0);
        chk("rst_eng_query", eng_query, '0);
        chk("rst_eng_value", eng_value, '0);
        chk("rst_eng_en", DW'(eng_en), DW'(1'b0));
        chk("rst_eng_rst_n", DW'(eng_rst_n), DW'(1'b0));
        chk("rst_req_ready", DW'(req_ready), DW'(0));
        chk("rst_job_count", DW'(job_count), DW'(0));

        // Reset during the 7th RUN cycle discards the job.
        eng_lat   = 0;
        rsp_ready = 1'b1;
        req_valid = 2'b01;
        @(posedge clk);
        #1;
        req_valid = '0;
        repeat (6) @(posedge clk);
        #1;
        chk("midrun_busy", DW'(busy), DW'(1'b1));
        chk("midrun_en", DW'(eng_en), DW'(1'b1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrun_rst_busy", DW'(busy), DW'(1'b0));
        chk("midrun_rst_en", DW'(eng_en), DW'(1'b0));
        chk("midrun_rst_rstn", DW'(eng_rst_n), DW'(1'b0));
        chk("midrun_rst_rsp", DW'(rsp_valid), DW'(1'b0));
        chk("midrun_rst_jc", DW'(job_count), DW'(0));
        chk("midrun_rst_key", eng_key, '0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("midrun_no_rsp", DW'(rsp_valid), DW'(1'b0));
        chk("midrun_no_count", DW'(job_count), DW'(0));

        for (int i = 0; i < 7; i++) begin
            run_job(tbl[i].vmask, tbl[i].lat, tbl[i].res, tbl[i].id, tbl[i].jc);
        end

        // Back-pressure: response held stable while rsp_ready is low.
        eng_lat   = 3;
        eng_res   = {64{8'h77}};
        rsp_ready = 1'b0;
        req_valid = 2'b11;
        #1;
        chk("bp_grant", DW'(req_ready), DW'(2'b01));
        @(posedge clk);
        #1;
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("bp_rsp_seen", DW'(rsp_valid), DW'(1'b1));
        for (int c = 0; c < 10; c++) begin
            chk("bp_valid", DW'(rsp_valid), DW'(1'b1));
            chk("bp_data", rsp_data, {64{8'h77}});
            chk("bp_id", DW'(rsp_id), DW'(0));
            chk("bp_en", DW'(eng_en), DW'(1'b0));
            chk("bp_ready", DW'(req_ready), DW'(0));
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        req_valid = '0;
        @(posedge clk);
        #1;
        chk("bp_idle", DW'(busy), DW'(1'b0));
        chk("bp_rsp_drop", DW'(rsp_valid), DW'(1'b0));
        chk("bp_job_count", DW'(job_count), DW'(8));

`ifdef ATTN_JOB_SCHED_WATCHDOG_EN
        run_job(2'b01, 0, 8'h88, 2'd0, 8'd9);
        run_job(2'b10, TO, 8'h99, 2'd1, 8'd10);
`else
        // Without the watchdog a silent engine keeps the scheduler in RUN.
        eng_lat   = 0;
        req_valid = 2'b01;
        @(posedge clk);
        #1;
        req_valid = '0;
        repeat (40) @(posedge clk);
        #1;
        chk("hang_busy", DW'(busy), DW'(1'b1));
        chk("hang_en", DW'(eng_en), DW'(1'b1));
        chk("hang_no_rsp", DW'(rsp_valid), DW'(1'b0));
        chk("hang_err", DW'(rsp_err), DW'(1'b0));
`endif

        do_reset();
        chk("wrap_start", DW'(job_count), DW'(0));
        for (int k = 1; k <= 256; k++) begin
            run_job(2'b01, 1, 8'(k), 2'd0, 8'(k));
        end
        chk("wrap_end", DW'(job_count), DW'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
